// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared 8N1 frame constants, rx state encoding and baud helper
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Core-clock cycles per serial symbol; shared with the transmitter.
    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_framer_if.sv
// rtl/uart_rx_framer_if.sv - received-byte holding register handshake and status pulses
interface uart_rx_framer_if;

    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       framing_error;
    logic       overrun;

    modport master (
        output data_out,
        output data_out_valid,
        output framing_error,
        output overrun,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        input  framing_error,
        input  overrun,
        output data_out_ready
    );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with selectable reset value
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the async input a full cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - 8N1 serial receiver with one-entry ready/valid holding register
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               serial_in,
    uart_rx_framer_if.master   rx_bus
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [2:0]       LAST_BIT    = 3'(DATA_BITS - 1);

    if (SYMBOL_EDGE_TIME < 4) begin : g_bad_rate
        $error("uart_rx_framer: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end

    logic rx_s;

    rx_state_t        state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [2:0]       bit_idx_q, bit_idx_n;
    logic [7:0]       shift_q, shift_n;
    logic [7:0]       data_q, data_n;
    logic             valid_q, valid_n;
    logic             fe_q, fe_n;
    logic             ov_q, ov_n;
    logic             drain;

    // Line idles high, so presetting the synchronizer to 1 avoids a false start edge at reset release.
    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_in),
        .q   (rx_s)
    );

    assign rx_bus.data_out       = data_q;
    assign rx_bus.data_out_valid = valid_q;
    assign rx_bus.framing_error  = fe_q;
    assign rx_bus.overrun        = ov_q;

    // State, counters, shift register and holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            bit_idx_q <= bit_idx_n;
            shift_q   <= shift_n;
            data_q    <= data_n;
            valid_q   <= valid_n;
            fe_q      <= fe_n;
            ov_q      <= ov_n;
        end
    end

    // Frame sequencing and holding-register update; pulses default low every cycle.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        bit_idx_n = bit_idx_q;
        shift_n   = shift_q;
        data_n    = data_q;
        valid_n   = valid_q;
        fe_n      = 1'b0;
        ov_n      = 1'b0;
        drain     = valid_q && rx_bus.data_out_ready;

        if (drain) begin
            valid_n = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end

            START: begin
                if (cnt_q == SAMPLE_LAST) begin
                    // Restarting the count here puts every later sample a full symbol on, i.e. mid-bit.
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == SYMBOL_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (cnt_q == SYMBOL_LAST) begin
                    // Leave at mid-stop so a start bit immediately after the stop bit is not missed.
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (rx_s) begin
                        if (!valid_q || drain) begin
                            data_n  = shift_q;
                            valid_n = 1'b1;
                        end else begin
                            ov_n = 1'b1;
                        end
                    end else begin
                        fe_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
